// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared constants, types and helpers for the refill splitter
package snitch_icache_pkg;
  localparam int unsigned BEAT_W = 8 + 1;
  localparam int unsigned FILL_DW_DEFAULT = 64;
  typedef enum logic {IDLE, ISSUE} state_e;
  typedef struct packed {
    logic                       last;
    logic                       error;
    logic [FILL_DW_DEFAULT-1:0] data;
  } rsp_entry_t;
  function automatic int unsigned credit_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/snitch_icache_refill_rspbuf.sv
// snitch_icache_refill_rspbuf: registered (non-fall-through) FIFO, output reads 0 when empty
module snitch_icache_refill_rspbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic do_pop;
  assign empty_o = cnt == '0;
  assign full_o = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop_i & ~empty_o;
  assign data_o = empty_o ? '0 : mem[rptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(push_i);
      rptr <= rptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= data_i;
  end
endmodule

// File: rtl/snitch_icache_refill_splitter.sv
// snitch_icache_refill_splitter: splits refill bursts into single-word memory reads with credit-bounded response buffering
module snitch_icache_refill_splitter import snitch_icache_pkg::*; #(
  parameter int unsigned FILL_AW = 32,
  parameter int unsigned FILL_DW = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FILL_AW-1:0] refill_qaddr_i,
  input  logic [7:0]         refill_qlen_i,
  input  logic               refill_qvalid_i,
  output logic               refill_qready_o,
  output logic [FILL_DW-1:0] refill_pdata_o,
  output logic               refill_perror_o,
  output logic               refill_plast_o,
  output logic               refill_pvalid_o,
  input  logic               refill_pready_i,
  output logic               mem_req_o,
  output logic [FILL_AW-1:0] mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [FILL_DW-1:0] mem_rdata_i,
  input  logic               mem_rerror_i
);
  localparam int unsigned OFF = $clog2(FILL_DW / 8);
  localparam int unsigned CW = credit_w(MAX_OUTSTANDING);
  state_e state_q, state_d;
  logic [FILL_AW-1:0] base_q;
  logic [7:0] len_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CW-1:0] credit_q;
  logic q_hs, gnt, p_hs, last_beat;
  logic lf_last, lf_empty, lf_full, rsp_empty, rsp_full;
  logic [FILL_DW+1:0] rsp_head;
  assign q_hs = refill_qvalid_i & refill_qready_o;
  assign gnt = mem_req_o & mem_gnt_i;
  assign p_hs = refill_pvalid_o & refill_pready_i;
  assign last_beat = beat_q == {1'b0, len_q};
  always_comb begin
    refill_qready_o = state_q == IDLE;
    mem_req_o = state_q == ISSUE && credit_q < CW'(MAX_OUTSTANDING);
    mem_addr_o = base_q + (FILL_AW'(beat_q) << OFF);
    state_d = state_q == IDLE ? (refill_qvalid_i ? ISSUE : IDLE) : (gnt && last_beat ? IDLE : ISSUE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      credit_q <= '0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_q + CW'(gnt) - CW'(p_hs);
      beat_q <= q_hs ? '0 : beat_q + BEAT_W'(gnt);
      if (q_hs) begin
        base_q <= (refill_qaddr_i >> OFF) << OFF;
        len_q <= refill_qlen_i;
      end
    end
  end
  snitch_icache_refill_rspbuf #(.DEPTH(MAX_OUTSTANDING), .WIDTH(1)) i_last_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt),
    .data_i  (last_beat),
    .pop_i   (mem_rvalid_i),
    .data_o  (lf_last),
    .empty_o (lf_empty),
    .full_o  (lf_full)
  );
  snitch_icache_refill_rspbuf #(.DEPTH(MAX_OUTSTANDING), .WIDTH(FILL_DW + 2)) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mem_rvalid_i),
    .data_i  ({lf_last, mem_rerror_i, mem_rdata_i}),
    .pop_i   (p_hs),
    .data_o  (rsp_head),
    .empty_o (rsp_empty),
    .full_o  (rsp_full)
  );
  assign {refill_plast_o, refill_perror_o, refill_pdata_o} = rsp_head;
  assign refill_pvalid_o = ~rsp_empty;
  assert property (@(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> !lf_empty);
  assert property (@(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> !rsp_full);
  assert property (@(posedge clk_i) disable iff (rst_i) gnt |-> !lf_full);
  assert property (@(posedge clk_i) disable iff (rst_i) mem_req_o && !mem_gnt_i |=> $stable(mem_addr_o));
endmodule
